// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider, DATA_W iterations per op.
// Define MULDIV_SIGNED_EN to honour sgn (magnitude conversion, sign fix-up, MIN/-1 overflow).
module muldiv_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        flags
);
  localparam int W = DATA_W;
  localparam logic [1:0]   OP_MULL = 2'b00;
  localparam logic [1:0]   OP_MULH = 2'b01;
  localparam logic [1:0]   OP_DIV  = 2'b10;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc, acc_nxt;
  logic [W-1:0]     shf;
  logic [W-1:0]     opd;
  logic [W-1:0]     a_raw;
  logic [1:0]       op_q;
  logic             sgn_q, neg_a_q, neg_b_q;
  logic             accept, last;

  // shf carries the multiplier (shifted right) or dividend (shifted left); opd the other operand
  logic         sgn_in, neg_a_in, neg_b_in;
  logic [W-1:0] mag_a, mag_b;
`ifdef MULDIV_SIGNED_EN
  assign sgn_in   = sgn;
  assign neg_a_in = sgn & a[W-1];
  assign neg_b_in = sgn & b[W-1];
  assign mag_a    = neg_a_in ? -a : a;
  assign mag_b    = neg_b_in ? -b : b;
`else
  logic unused_signs;
  assign unused_signs = ^{sgn, sgn_q, neg_a_q, neg_b_q};
  assign sgn_in   = 1'b0;
  assign neg_a_in = 1'b0;
  assign neg_b_in = 1'b0;
  assign mag_a    = a;
  assign mag_b    = b;
`endif

  assign accept = start && (state == IDLE || state == FIN);
  assign last   = (state == RUN) && (cnt == CNT_W'(W - 1));
  assign busy   = (state == RUN);
  assign done   = (state == FIN);

  // One iteration: add-and-shift for multiply, trial subtract for divide
  logic [W:0]   mul_sum, div_shift;
  logic [W-1:0] div_diff;
  logic         div_ge;
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (shf[0] ? opd : '0)};
    div_shift = {acc[2*W-1:W], shf[W-1]};
    div_ge    = (div_shift >= {1'b0, opd});
    div_diff  = div_shift[W-1:0] - opd;
    if (!op_q[1])
      acc_nxt = {mul_sum, acc[W-1:1]};
    else
      acc_nxt = {(div_ge ? div_diff : div_shift[W-1:0]), acc[W-2:0], div_ge};
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic           ovf, div0, c_mull;
  assign div0 = (opd == '0);
`ifdef MULDIV_SIGNED_EN
  assign prod   = (neg_a_q ^ neg_b_q) ? -acc_nxt : acc_nxt;
  assign quo    = (neg_a_q ^ neg_b_q) ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
  assign rem    = neg_a_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
  assign ovf    = neg_b_q && (opd == W'(1)) && (a_raw == MIN_VAL);
  assign c_mull = sgn_q ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[2*W-1:W] != '0);
`else
  assign prod   = acc_nxt;
  assign quo    = acc_nxt[W-1:0];
  assign rem    = acc_nxt[2*W-1:W];
  assign ovf    = 1'b0;
  assign c_mull = (prod[2*W-1:W] != '0);
`endif

  // Final result selection, with divide-by-zero and MIN/-1 overriding the arithmetic
  logic [W-1:0] res;
  logic         res_c, res_v;
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_MULL: begin
        res   = prod[W-1:0];
        res_c = c_mull;
      end
      OP_MULH: res = prod[2*W-1:W];
      OP_DIV: begin
        if (div0)     begin res = '1;      res_v = 1'b1; end
        else if (ovf) begin res = MIN_VAL; res_v = 1'b1; end
        else                res = quo;
      end
      default: begin
        if (div0)     begin res = a_raw; res_v = 1'b1; end
        else if (ovf) begin res = '0;    res_v = 1'b1; end
        else                res = rem;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // y/flags load on the last iteration edge so they are valid in the FIN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      shf     <= '0;
      opd     <= '0;
      a_raw   <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      y       <= '0;
      flags   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op;
        sgn_q   <= sgn_in;
        neg_a_q <= neg_a_in;
        neg_b_q <= neg_b_in;
        a_raw   <= a;
        acc     <= '0;
        cnt     <= '0;
        shf     <= op[1] ? mag_a : mag_b;
        opd     <= op[1] ? mag_b : mag_a;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        shf <= op_q[1] ? (shf << 1) : (shf >> 1);
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          y     <= res;
          flags <= {res[W-1], (res == '0), res_c, res_v};
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios plus randomized ops against an integer-arithmetic model.
// Signed scenarios are included when MULDIV_SIGNED_EN is defined for the build.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, sgn, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, y;
  logic [3:0]   flags;
  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn),
    .a(a), .b(b), .busy(busy), .done(done), .y(y), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {y, N, Z, C, V}
  function automatic logic [19:0] model(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                                        input logic [W-1:0] z);
    longint xa, zb, p, r;
    logic [W-1:0] yy;
    logic c, v, s_eff;
    s_eff = s;
`ifndef MULDIV_SIGNED_EN
    s_eff = 1'b0;
`endif
    c = 1'b0; v = 1'b0; yy = '0;
    if (s_eff) begin xa = longint'($signed(x)); zb = longint'($signed(z)); end
    else       begin xa = longint'(x);          zb = longint'(z);          end
    p = xa * zb;
    case (o)
      2'b00: begin
        yy = p[15:0];
        c  = s_eff ? (p < -32768 || p > 32767) : (p > 65535);
      end
      2'b01: yy = p[31:16];
      2'b10: begin
        if (z == 0) begin yy = 16'hFFFF; v = 1'b1; end
        else if (s_eff && x == 16'h8000 && z == 16'hFFFF) begin yy = 16'h8000; v = 1'b1; end
        else begin r = xa / zb; yy = r[15:0]; end
      end
      default: begin
        if (z == 0) begin yy = x; v = 1'b1; end
        else if (s_eff && x == 16'h8000 && z == 16'hFFFF) begin yy = 16'h0000; v = 1'b1; end
        else begin r = xa % zb; yy = r[15:0]; end
      end
    endcase
    return {yy, yy[15], (yy == 16'h0000), c, v};
  endfunction

  // Pulse start for one cycle and wait (bounded) for done; lat counts samples after the start edge
  task automatic apply_stimulus(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                                input logic [W-1:0] z, output int lat, output int busy_cyc);
    op = o; sgn = s; a = x; b = z; start = 1'b1;
    lat = 0; busy_cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) busy_cyc++;
    end while (!done && lat < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if ({y, flags} !== 20'h0) $display("[TB] FAIL reset_y_flags: got %h want 00000", {y, flags}); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int lat, bc;
    apply_stimulus(2'b00, 1'b0, 16'd300, 16'd200, lat, bc);
    n_checks++; if (lat !== 17) $display("[TB] FAIL latency_mull: got %0d want 17", lat); else n_pass++;
    n_checks++; if (bc !== 16) $display("[TB] FAIL busy_cycles: got %0d want 16", bc); else n_pass++;
    n_checks++; if ({y, flags} !== {16'hEA60, 4'b1000}) $display("[TB] FAIL mull_300x200: got %h want ea608", {y, flags}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) $display("[TB] FAIL done_pulse_width: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    apply_stimulus(2'b01, 1'b0, 16'h1234, 16'h5678, lat, bc);
    n_checks++; if ({y, flags} !== {16'h0626, 4'b0000}) $display("[TB] FAIL mulh_halves: got %h want 06260", {y, flags}); else n_pass++;
    apply_stimulus(2'b00, 1'b0, 16'h1234, 16'h5678, lat, bc);
    n_checks++; if (lat !== 17) $display("[TB] FAIL b2b_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if ({y, flags} !== {16'h0060, 4'b0010}) $display("[TB] FAIL mull_halves: got %h want 00602", {y, flags}); else n_pass++;
  endtask

  task automatic test_unsigned_div();
    int lat, bc;
    op = 2'b10; sgn = 1'b0; a = 16'd1000; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL accept_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if ({y, flags} !== {16'h0060, 4'b0010}) $display("[TB] FAIL hold_on_accept: got %h want 00602", {y, flags}); else n_pass++;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 17) $display("[TB] FAIL div_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if ({y, flags} !== {16'h008E, 4'b0000}) $display("[TB] FAIL div_1000_7: got %h want 008e0", {y, flags}); else n_pass++;
    apply_stimulus(2'b11, 1'b0, 16'd1000, 16'd7, lat, bc);
    n_checks++; if ({y, flags} !== {16'h0006, 4'b0000}) $display("[TB] FAIL rem_1000_7: got %h want 00060", {y, flags}); else n_pass++;
    apply_stimulus(2'b10, 1'b0, 16'd0, 16'd5, lat, bc);
    n_checks++; if ({y, flags} !== {16'h0000, 4'b0100}) $display("[TB] FAIL div_0_5: got %h want 00004", {y, flags}); else n_pass++;
  endtask

  task automatic test_div_zero();
    int lat, bc;
    apply_stimulus(2'b10, 1'b0, 16'h00FF, 16'h0000, lat, bc);
    n_checks++; if (lat !== 17) $display("[TB] FAIL div0_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if ({y, flags} !== {16'hFFFF, 4'b1001}) $display("[TB] FAIL div0_quo: got %h want ffff9", {y, flags}); else n_pass++;
    apply_stimulus(2'b11, 1'b0, 16'h00FF, 16'h0000, lat, bc);
    n_checks++; if ({y, flags} !== {16'h00FF, 4'b0001}) $display("[TB] FAIL div0_rem: got %h want 00ff1", {y, flags}); else n_pass++;
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    int lat, bc;
    apply_stimulus(2'b10, 1'b1, 16'hFFF9, 16'h0002, lat, bc);
    n_checks++; if ({y, flags} !== {16'hFFFD, 4'b1000}) $display("[TB] FAIL sdiv_m7_2: got %h want fffd8", {y, flags}); else n_pass++;
    apply_stimulus(2'b11, 1'b1, 16'hFFF9, 16'h0002, lat, bc);
    n_checks++; if ({y, flags} !== {16'hFFFF, 4'b1000}) $display("[TB] FAIL srem_m7_2: got %h want ffff8", {y, flags}); else n_pass++;
    apply_stimulus(2'b10, 1'b1, 16'h8000, 16'hFFFF, lat, bc);
    n_checks++; if ({y, flags} !== {16'h8000, 4'b1001}) $display("[TB] FAIL sdiv_overflow: got %h want 80009", {y, flags}); else n_pass++;
    apply_stimulus(2'b00, 1'b1, 16'hFFFE, 16'h0003, lat, bc);
    n_checks++; if ({y, flags} !== {16'hFFFA, 4'b1000}) $display("[TB] FAIL smull_m2_3: got %h want fffa8", {y, flags}); else n_pass++;
  endtask
`endif

  task automatic test_random();
    int lat, bc;
    logic [1:0]   o;
    logic         s;
    logic [W-1:0] x, z;
    logic [19:0]  exp_v;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       z = 16'h0000;
        1:       z = 16'($urandom_range(1, 15));
        2:       z = 16'hFFFF;
        default: z = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) x = 16'h8000;
      exp_v = model(o, s, x, z);
      apply_stimulus(o, s, x, z, lat, bc);
      n_checks++; if (lat !== 17) $display("[TB] FAIL rand_latency[%0d]: got %0d want 17", i, lat); else n_pass++;
      n_checks++;
      if ({y, flags} !== exp_v)
        $display("[TB] FAIL rand_result[%0d] op=%b sgn=%b a=%h b=%h: got %h want %h", i, o, s, x, z, {y, flags}, exp_v);
      else n_pass++;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_disturb_start();
    int lat;
    op = 2'b00; sgn = 1'b0; a = 16'd300; b = 16'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    op = 2'b11; a = 16'h1111; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 17) $display("[TB] FAIL disturb_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if ({y, flags} !== {16'hEA60, 4'b1000}) $display("[TB] FAIL disturb_result: got %h want ea608", {y, flags}); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, done_seen;
    op = 2'b01; sgn = 1'b0; a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({y, flags} !== 20'h0) $display("[TB] FAIL abort_y_flags: got %h want 00000", {y, flags}); else n_pass++;
    done_seen = 0;
    repeat (20) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (done_seen !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses want 0", done_seen); else n_pass++;
    apply_stimulus(2'b10, 1'b0, 16'd1000, 16'd7, lat, bc);
    n_checks++; if (lat !== 17) $display("[TB] FAIL after_abort_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if ({y, flags} !== {16'h008E, 4'b0000}) $display("[TB] FAIL after_abort_result: got %h want 008e0", {y, flags}); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; sgn = 1'b0; a = '0; b = '0;
    $display("[TB] starting muldiv_unit bench");
    test_reset();
    test_latency();
    test_back_to_back();
    test_unsigned_div();
    test_div_zero();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_disturb_start();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
